// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter and its picker.
// The command record is the payload of the registered command stage.
package dmem_pkg;

  localparam int N_CORES = 8;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int ID_W    = $clog2(N_CORES);

  typedef struct packed {
    logic              v;
    logic              we;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  function automatic logic [N_CORES-1:0] onehot(input logic [ID_W-1:0] idx);
    return N_CORES'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
// Zero latency, no state; o_vld low when no request is set.
module rr_picker #(
  parameter int N = 8
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_vld
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] w_cand;

  // Scan from farthest to nearest so the candidate closest to i_ptr overwrites the rest.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_vld  = 1'b0;
    w_cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = i_ptr + IW'(k);
      if (i_req[w_cand]) begin
        o_gnt         = '0;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
        o_vld         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin, lockable arbiter sharing one Data_memory port among N_CORES cores.
// Grant same cycle, command T+1, rvalid T+2; no return backpressure, losers hold req.
module dmem_arbiter #(
  parameter int N_CORES = 8,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CORES-1:0]        req,
  input  logic [N_CORES-1:0]        we,
  input  logic [N_CORES-1:0]        lock,
  input  logic [N_CORES*ADDR_W-1:0] addr,
  input  logic [N_CORES*DATA_W-1:0] wdata,
  output logic [N_CORES-1:0]        gnt,
  output logic [N_CORES-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  import dmem_pkg::*;

  localparam int ID_W = $clog2(N_CORES);

  logic [ID_W-1:0]    r_ptr;
  logic               r_locked;
  logic [ID_W-1:0]    r_owner;
  cmd_t               r_cmd;
  logic               r_rsp_v;
  logic [ID_W-1:0]    r_rsp_id;

  logic [N_CORES-1:0] w_rr_gnt;
  logic [ID_W-1:0]    w_rr_idx;
  logic               w_rr_vld;
  logic               w_hold;
  logic [N_CORES-1:0] w_gnt;
  logic [ID_W-1:0]    w_idx;
  logic               w_vld;

  rr_picker #(.N(N_CORES)) u_rr_picker (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_rr_gnt),
    .o_idx (w_rr_idx),
    .o_vld (w_rr_vld)
  );

  // The lock only holds while the owner keeps lock high; the release cycle arbitrates normally.
  assign w_hold = r_locked & lock[r_owner];

  always_comb begin
    w_gnt = '0;
    w_idx = r_owner;
    w_vld = 1'b0;
    if (rst_n) begin
      if (w_hold) begin
        if (req[r_owner]) begin
          w_gnt = onehot(r_owner);
          w_vld = 1'b1;
        end
      end else begin
        w_gnt = w_rr_gnt;
        w_idx = w_rr_idx;
        w_vld = w_rr_vld;
      end
    end
  end

  assign gnt = w_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_locked <= 1'b0;
      r_owner  <= '0;
      r_cmd    <= '0;
      r_rsp_v  <= 1'b0;
      r_rsp_id <= '0;
    end else begin
      r_cmd.v <= w_vld;
      if (w_vld) begin
        r_ptr       <= w_idx + 1'b1;
        r_cmd.we    <= we[w_idx];
        r_cmd.id    <= w_idx;
        r_cmd.addr  <= addr[w_idx*ADDR_W +: ADDR_W];
        r_cmd.wdata <= wdata[w_idx*DATA_W +: DATA_W];
      end

      if (w_vld && lock[w_idx]) begin
        r_locked <= 1'b1;
        r_owner  <= w_idx;
      end else if (r_locked && !lock[r_owner]) begin
        r_locked <= 1'b0;
      end

      r_rsp_v  <= r_cmd.v & ~r_cmd.we;
      r_rsp_id <= r_cmd.id;
    end
  end

  // Gating with rst_n keeps an in-flight command from touching memory once reset is seen.
  assign mem_read  = rst_n & r_cmd.v & ~r_cmd.we;
  assign mem_write = rst_n & r_cmd.v & r_cmd.we;
  assign mem_addr  = r_cmd.addr;
  assign mem_wdata = r_cmd.wdata;

  always_comb begin
    rvalid = '0;
    if (rst_n && r_rsp_v) begin
      rvalid = onehot(r_rsp_id);
    end
  end

  assign rdata = mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter that shares the single-port 16-bit `Data_memory` among the 8 cores of the matrix-multiplication processor. Each core posts one read or write per handshake. The arbiter picks one winner per cycle, issues that access to the memory through a registered command stage, and routes the read data back to the requesting core with a tagged valid. An optional per-core lock keeps ownership across a read-modify-write sequence, which the accumulate step of the multiply needs.

## Interface
- `N_CORES`, 8, number of requesters (power of 2, ≥2)
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `req`  in  N_CORES  per-core request, held until granted
- `we`  in  N_CORES  per-core write enable (1 = write, 0 = read)
- `lock`  in  N_CORES  per-core hold-ownership request
- `addr`  in  N_CORES*ADDR_W  per-core address, core i at bits [i*ADDR_W +: ADDR_W]
- `wdata`  in  N_CORES*DATA_W  per-core write data, same packing
- `gnt`  out  N_CORES  one-hot grant, combinational, same cycle as the accepted request
- `rvalid`  out  N_CORES  one-hot read-data valid, one cycle
- `rdata`  out  DATA_W  read data, shared by all cores
- `mem_read`  out  1  to `Data_memory` read
- `mem_write`  out  1  to `Data_memory` write
- `mem_addr`  out  ADDR_W  to `Data_memory` address
- `mem_wdata`  out  DATA_W  to `Data_memory` data_in
- `mem_rdata`  in  DATA_W  from `Data_memory` data_out

## Operation
- **Handshake**
  - A transfer occurs on a cycle where `req[i] & gnt[i]`.
  - Core i holds `we`, `addr` and `wdata` stable while `req[i]` is high and not yet granted.
  - At most one `gnt` bit is high per cycle.
- **Arbitration**
  - Round-robin priority pointer `ptr`, reset value 0.
  - The winner is the first set `req` bit at or after `ptr`, wrapping around.
  - After a grant to core i, `ptr` becomes (i+1) mod N_CORES.
  - When no request is granted, `ptr` is unchanged.
- **Lock**
  - Lock state `{locked, owner}`, reset value `{0, 0}`.
  - A grant to core i with `lock[i]=1` sets `locked=1`, `owner=i`.
  - While `locked`, only `owner` can be granted. Other requests wait, and their `gnt` stays 0.
  - `locked` clears on the first cycle `lock[owner]=0`. A grant is possible in that same cycle under normal round-robin.
  - `ptr` still advances on owner grants.
- **Command stage**
  - Registered signals: `cmd_v`, `cmd_we`, `cmd_id`, `mem_addr`, `mem_wdata`.
  - Loaded from the winner every cycle a grant occurs.
  - `mem_read = cmd_v & ~cmd_we`; `mem_write = cmd_v & cmd_we`.
- **Read return stage**
  - Registered `rsp_v`, `rsp_id`, loaded from the command stage when it holds a read.
  - `rvalid[rsp_id] = rsp_v`; `rdata = mem_rdata` passed through.
- **Ordering**
  - Accesses reach memory in grant order.
  - A read granted after a write to the same address returns the new data.
- **Throughput**: one access per cycle, fully pipelined, no backpressure on the return path.

## Timing
- **Reset values**
  - `mem_read`, `mem_write`, `rvalid`: 0.
  - `mem_addr`, `mem_wdata`: 0.
  - `rdata` follows `mem_rdata`.
  - `gnt`: 0 while `rst_n=0`.
- **Latency** (grant in cycle T):
  - memory command is driven in cycle T+1;
  - a write is committed at the T+1→T+2 edge;
  - read data appears with `rvalid` in cycle T+2. `Data_memory` has a registered read: `data_out` is valid the cycle after `mem_read`.
- **Back-to-back**: grants in T and T+1 produce two consecutive memory commands and two consecutive `rvalid` pulses, possibly to different cores.
- **Reset mid-operation**: all in-flight command and return stages are discarded. No `rvalid` is produced for transactions granted before reset; `ptr` and lock return to 0.
- **Simultaneous events**: a request from the current owner in the unlock cycle is arbitrated round-robin against all other requests.

## Structure
- Shared package `dmem_pkg` holds:
  - `N_CORES`, `ADDR_W`, `DATA_W` defaults;
  - `ID_W = $clog2(N_CORES)`;
  - the command record type (`v`, `we`, `id`, `addr`, `wdata`).
- One sub-module: `rr_picker`. It is the combinational round-robin picker: `req` vector plus `ptr` in, one-hot grant plus encoded index out. It is reused by the other shared-resource arbiters in the processor.

## Test plan
- **Reset**: hold `rst_n=0` 3 cycles with all `req=8'hFF` → `gnt=0`, `mem_read=mem_write=0`, `rvalid=0`. After release, the first grant is core 0.
- **Single read**: core 3 reads address 10, memory preloaded with word[10]=16'h00AB → `gnt[3]` in T, `mem_read=1`/`mem_addr=10` in T+1, `rvalid=8'h08` with `rdata=16'h00AB` in T+2.
- **All requesting**: all 8 cores request for 16 cycles → grant order 0,1,…,7,0,…,7 with one grant per cycle and 16 `rvalid` pulses whose ids match the grant order.
- **Write then read**: core 1 writes address 14 = 23; core 1 then reads address 14 on the next cycle → word[14]=23 after the write, and the read returns 23.
- **Lock**: core 2 does a locked read of address 17, then a write of address 17 = 5, then drops `lock`; cores 0 and 5 request throughout → no grant to 0 or 5 until `lock[2]=0`, then grants go 5, then 0 (the pointer is at 3).
- **Reset mid-flight**: core 6 read granted in T and `rst_n=0` in T+1 → no `rvalid` at T+2, and `ptr` is back to 0.
